// File: rtl/reg_file_wb.sv
// Architectural register file with write-first bypass read ports and a
// per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
module reg_file_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            issue_valid,
  input  logic            issue_rs1_used,
  input  logic            issue_rs2_used,
  input  logic            issue_we,
  input  logic [AW-1:0]   issue_rd,
  output logic            stall,
  output logic [AW:0]     pending_cnt
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pending_q, pending_d;
  logic [AW:0]     pending_cnt_q, pending_cnt_d;

  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic busy1, busy2, rd_busy;
  logic accept, set_fire, clr_fire;
  logic cnt_inc, cnt_dec;

  assign wb_hit1   = wb_en && (wb_rd == rs1_addr);
  assign wb_hit2   = wb_en && (wb_rd == rs2_addr);
  assign wb_hit_rd = wb_en && (wb_rd == issue_rd);

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != '0) begin
      if (wb_hit1) rs1_data = wb_data;
      else         rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != '0) begin
      if (wb_hit2) rs2_data = wb_data;
      else         rs2_data = regs_q[rs2_addr];
    end
  end

  // A same-cycle writeback resolves the hazard through the bypass.
  assign busy1   = pending_q[rs1_addr] && !wb_hit1 && (rs1_addr != '0);
  assign busy2   = pending_q[rs2_addr] && !wb_hit2 && (rs2_addr != '0);
  assign rd_busy = issue_we && pending_q[issue_rd] && !wb_hit_rd && (issue_rd != '0);

  assign stall    = issue_valid &&
                    ((issue_rs1_used && busy1) || (issue_rs2_used && busy2) || rd_busy);
  assign accept   = issue_valid && !stall;
  assign set_fire = accept && issue_we && (issue_rd != '0);
  assign clr_fire = wb_en && (wb_rd != '0);

  // Set is applied after clear so a new producer keeps ownership of the bit.
  always_comb begin
    pending_d = pending_q;
    if (clr_fire) pending_d[wb_rd]    = 1'b0;
    if (set_fire) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_inc = set_fire && !pending_q[issue_rd];
    cnt_dec = clr_fire && pending_q[wb_rd] && !(set_fire && (issue_rd == wb_rd));
    pending_cnt_d = pending_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (clr_fire) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      pending_cnt_q <= '0;
    end else begin
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed testbench for reg_file_wb: bypass reads, x0 handling, scoreboard
// stalls, set/clear collisions and asynchronous reset.
module tb_reg_file_wb;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_valid, issue_rs1_used, issue_rs2_used, issue_we;
  logic [4:0]  issue_rd;
  logic        stall;
  logic [5:0]  pending_cnt;

  int total = 0;
  int bad   = 0;

  reg_file_wb #(.XLEN(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_rs1_used(issue_rs1_used),
    .issue_rs2_used(issue_rs2_used), .issue_we(issue_we), .issue_rd(issue_rd),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; issue_rs1_used = 0; issue_rs2_used = 0; issue_we = 0; issue_rd = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    issue_valid = 1; issue_we = 1; issue_rd = rd;
    issue_rs1_used = 0; issue_rs2_used = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; rs1_addr = 5; rs2_addr = 0;
    #12;
    rst_n = 1;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, 32'h0); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, 32'h0); end
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pending_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tick();
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_rd = 7; wb_data = 32'hDEADBEEF; rs1_addr = 7; rs2_addr = 7;
    #1;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", rs1_data); end
    total++; if (rs2_data !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rs2 got=%h exp=deadbeef", rs2_data); end
    tick();
    idle_inputs();
    #1;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_rs1 got=%h exp=deadbeef", rs1_data); end
    wb_en = 1; wb_rd = 1; wb_data = 32'h000000A1;
    tick();
    idle_inputs();
    rs2_addr = 1;
    #1;
    total++; if (rs2_data !== 32'h000000A1) begin bad++; $display("FAIL stored_rs2 got=%h exp=000000a1", rs2_data); end
  endtask

  task automatic test_x0_write();
    wb_en = 1; wb_rd = 0; wb_data = 32'h12345678; rs1_addr = 0;
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_bypass got=%h exp=0", rs1_data); end
    tick();
    idle_inputs();
    #1;
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL x0_cnt got=%0d exp=0", pending_cnt); end
  endtask

  task automatic test_raw();
    issue_write(3);
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_first_stall got=%b exp=0", stall); end
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL raw_cnt_set got=%0d exp=1", pending_cnt); end
    idle_inputs();
    issue_valid = 1; issue_rs1_used = 1; rs1_addr = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_rs1 got=%b exp=1", stall); end
    issue_rs1_used = 0; issue_rs2_used = 1; rs2_addr = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_rs2 got=%b exp=1", stall); end
    issue_rs2_used = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_unused_stall got=%b exp=0", stall); end
    issue_rs1_used = 1;
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL raw_cnt_hold got=%0d exp=1", pending_cnt); end
    wb_en = 1; wb_rd = 3; wb_data = 32'h55;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_wb_stall got=%b exp=0", stall); end
    total++; if (rs1_data !== 32'h55) begin bad++; $display("FAIL raw_wb_rs1 got=%h exp=55", rs1_data); end
    tick();
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL raw_cnt_clr got=%0d exp=0", pending_cnt); end
    idle_inputs();
  endtask

  task automatic test_set_clear_same();
    issue_write(4);
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL same_cnt_set got=%0d exp=1", pending_cnt); end
    wb_en = 1; wb_rd = 4; wb_data = 32'h44;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL same_waw_resolved got=%b exp=0", stall); end
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL same_cnt_keep got=%0d exp=1", pending_cnt); end
    wb_en = 0;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL same_waw_stall got=%b exp=1", stall); end
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL same_cnt_stalled got=%0d exp=1", pending_cnt); end
    idle_inputs();
    wb_en = 1; wb_rd = 4;
    tick();
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL same_cnt_drain got=%0d exp=0", pending_cnt); end
    idle_inputs();
  endtask

  task automatic test_set_clear_diff();
    issue_write(9);
    tick();
    issue_write(10);
    wb_en = 1; wb_rd = 9;
    tick();
    total++; if (pending_cnt !== 6'd1) begin bad++; $display("FAIL diff_cnt got=%0d exp=1", pending_cnt); end
    idle_inputs();
    issue_valid = 1; issue_rs1_used = 1; rs1_addr = 9;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL diff_r9_free got=%b exp=0", stall); end
    issue_rs1_used = 0; issue_rs2_used = 1; rs2_addr = 10;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL diff_r10_busy got=%b exp=1", stall); end
    idle_inputs();
    wb_en = 1; wb_rd = 10;
    tick();
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL diff_cnt_drain got=%0d exp=0", pending_cnt); end
    wb_rd = 12;
    tick();
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL nonpending_clr got=%0d exp=0", pending_cnt); end
    idle_inputs();
    rs1_addr = 5'bx; rs2_addr = 5'bx;
    tick();
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL xaddr_cnt got=%0d exp=0", pending_cnt); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL xaddr_stall got=%b exp=0", stall); end
  endtask

  task automatic test_async_reset();
    issue_write(1); tick();
    issue_write(2); tick();
    issue_write(3); tick();
    total++; if (pending_cnt !== 6'd3) begin bad++; $display("FAIL ar_cnt_pre got=%0d exp=3", pending_cnt); end
    idle_inputs();
    rs1_addr = 7; rs2_addr = 1;
    #1;
    total++; if (rs1_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ar_rs1_pre got=%h exp=deadbeef", rs1_data); end
    #2;
    rst_n = 0;
    #1;
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", pending_cnt); end
    total++; if (rs1_data !== 32'h0) begin bad++; $display("FAIL ar_rs1 got=%h exp=0", rs1_data); end
    total++; if (rs2_data !== 32'h0) begin bad++; $display("FAIL ar_rs2 got=%h exp=0", rs2_data); end
    tick();
    rst_n = 1;
    issue_valid = 1; issue_rs1_used = 1; rs1_addr = 2;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ar_stall got=%b exp=0", stall); end
    idle_inputs();
    wb_en = 1; wb_rd = 2; wb_data = 32'hCAFE0002;
    tick();
    idle_inputs();
    rs1_addr = 2;
    #1;
    total++; if (rs1_data !== 32'hCAFE0002) begin bad++; $display("FAIL ar_late_wb got=%h exp=cafe0002", rs1_data); end
    total++; if (pending_cnt !== 6'd0) begin bad++; $display("FAIL ar_late_cnt got=%0d exp=0", pending_cnt); end
  endtask

  initial begin
    rst_n = 1; rs1_addr = 0; rs2_addr = 0;
    idle_inputs();
    test_reset();
    test_bypass();
    test_x0_write();
    test_raw();
    test_set_clear_same();
    test_set_clear_diff();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
